clk_gen_freq_meter: RTL and testbench

Measures the frequency of the free-running ring oscillator output against the system clock. It counts oscillator rising edges over a programmable window of system-clock cycles and returns the count through a valid/ready handshake. It sits on the consuming side of the clock generator, after the inverter-chain stages, and feeds oscillator calibration and tap-selection logic.

---
 rtl/clk_gen_pkg.sv | 15 +
 rtl/clk_gen_sync_edge.sv | 56 +++++
 rtl/clk_gen_freq_meter.sv | 107 ++++++++++
 tb/tb_clk_gen_freq_meter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-generator frequency meter: FSM state
// encoding and default parameter values.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int DEF_WINDOW_W    = 16;
  localparam int DEF_COUNT_W     = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_gen_sync_edge.sv
// Synchronizes the asynchronous oscillator into clk_i and emits a one-cycle
// rise pulse. CLK_GEN_FREQ_METER_GLITCH_FILTER_EN adds a two-sample level filter.
module clk_gen_sync_edge
  import clk_gen_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic osc_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_i};
    end
  end

`ifdef CLK_GEN_FREQ_METER_GLITCH_FILTER_EN
  logic filt_q;

  // The last two synchronizer stages are consecutive samples; only follow
  // the input once both agree, which swallows single-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
      filt_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~prev_q;

endmodule

// File: rtl/clk_gen_freq_meter.sv
// Counts oscillator rising edges over a programmable window of clk_i cycles
// and hands the result out over valid/ready. Optional: CLK_GEN_FREQ_METER_GLITCH_FILTER_EN.
module clk_gen_freq_meter
  import clk_gen_pkg::*;
#(
  parameter int WINDOW_W    = DEF_WINDOW_W,
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               osc_i,
  input  logic               start_v_i,
  output logic               start_ready_o,
  input  logic [WINDOW_W-1:0] window_i,
  output logic               count_v_o,
  input  logic               count_ready_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               saturated_o,
  output logic               busy_o
);

  localparam logic [COUNT_W-1:0]  CNT_MAX = '1;
  localparam logic [COUNT_W-1:0]  CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_W-1:0] WIN_ONE = {{(WINDOW_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [WINDOW_W-1:0] rem_q, rem_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                sat_q, sat_d;
  logic                osc_level;
  logic                osc_rise;

  clk_gen_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .osc_i    (osc_i),
    .level_o  (osc_level),
    .rise_o   (osc_rise)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    count_d = count_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start_v_i) begin
          count_d = '0;
          sat_d   = 1'b0;
          if (window_i == '0) begin
            state_d = DONE;
          end else begin
            rem_d   = window_i;
            state_d = MEASURE;
          end
        end
      end
      MEASURE: begin
        rem_d = rem_q - WIN_ONE;
        if (osc_rise) begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
          // Sticky once the counter has reached all-ones.
          if (count_q >= CNT_MAX - CNT_ONE) begin
            sat_d = 1'b1;
          end
        end
        if (rem_q == WIN_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (count_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so the request side looks closed while reset is held.
  assign start_ready_o = (state_q == IDLE) & reset_n_i;
  assign count_v_o     = (state_q == DONE);
  assign busy_o        = (state_q == MEASURE);
  assign count_o       = count_q;
  assign saturated_o   = sat_q;

endmodule

// File: tb/tb_clk_gen_freq_meter.sv
// Directed bench for clk_gen_freq_meter: a 16-bit and a 4-bit counter instance
// share stimulus; expected results go through a scoreboard queue.
module tb_clk_gen_freq_meter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        osc = 1'b0;
  logic        start_v = 1'b0;
  logic [15:0] window = '0;
  logic        count_ready = 1'b0;

  logic        start_ready, count_v, saturated, busy;
  logic [15:0] count;
  logic        start_ready4, count_v4, saturated4, busy4;
  logic [3:0]  count4;

  int total = 0;
  int bad   = 0;
  int osc_mode = 0;
  int osc_cnt  = 0;

  typedef struct {
    int lo;  int hi;  int sat;
    int lo4; int hi4; int sat4;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  clk_gen_freq_meter dut (
    .clk_i(clk), .reset_n_i(reset_n), .osc_i(osc),
    .start_v_i(start_v), .start_ready_o(start_ready), .window_i(window),
    .count_v_o(count_v), .count_ready_i(count_ready), .count_o(count),
    .saturated_o(saturated), .busy_o(busy)
  );

  clk_gen_freq_meter #(.COUNT_W(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .osc_i(osc),
    .start_v_i(start_v), .start_ready_o(start_ready4), .window_i(window),
    .count_v_o(count_v4), .count_ready_i(count_ready), .count_o(count4),
    .saturated_o(saturated4), .busy_o(busy4)
  );

  // Oscillator model, shifted off the clock edge: mode 1 = f_clk/4 square
  // wave, mode 2 = one-cycle pulse every 8 cycles, otherwise held low.
  always @(posedge clk) begin
    #3;
    osc_cnt = osc_cnt + 1;
    case (osc_mode)
      1:       if (osc_cnt % 2 == 0) osc = ~osc;
      2:       osc = (osc_cnt % 8 == 0);
      default: osc = 1'b0;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Issue one start, verify busy/latency, compare the result against the
  // scoreboard, optionally stall the consumer, then transfer.
  task automatic run_meas(input string tag, input int w, input exp_t e, input bit hold);
    int   n;
    int   busy_cnt;
    int   held;
    exp_t x;
    @(negedge clk);
    check({tag, ".start_ready"}, int'(start_ready), 1);
    start_v = 1'b1;
    window  = 16'(w);
    sb.push_back(e);
    @(negedge clk);
    start_v  = 1'b0;
    n        = 1;
    busy_cnt = 0;
    while (count_v !== 1'b1 && n <= w + 5) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, w + 1);
    check({tag, ".busy_cycles"}, busy_cnt, w);
    x = sb.pop_front();
    check_rng({tag, ".count"}, int'(count), x.lo, x.hi);
    check({tag, ".sat"}, int'(saturated), x.sat);
    check({tag, ".count_v4"}, int'(count_v4), 1);
    check_rng({tag, ".count4"}, int'(count4), x.lo4, x.hi4);
    check({tag, ".sat4"}, int'(saturated4), x.sat4);
    $display("txn %s window=%0d count=%0d sat=%0d count4=%0d sat4=%0d",
             tag, w, count, saturated, count4, saturated4);
    if (hold) begin
      held    = int'(count);
      start_v = 1'b1;
      window  = 16'd5;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check({tag, ".hold_count"}, int'(count), held);
        check({tag, ".hold_valid"}, int'(count_v), 1);
        check({tag, ".hold_ready"}, int'(start_ready), 0);
      end
      start_v = 1'b0;
    end
    count_ready = 1'b1;
    @(negedge clk);
    count_ready = 1'b0;
    check({tag, ".post_valid"}, int'(count_v), 0);
    check({tag, ".post_ready"}, int'(start_ready), 1);
  endtask

  initial begin
    exp_t e;
    int   seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.start_ready", int'(start_ready), 0);
    check("rst.count_v", int'(count_v), 0);
    check("rst.count", int'(count), 0);
    check("rst.sat", int'(saturated), 0);
    check("rst.busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst.ready_after", int'(start_ready), 1);

    // f_clk/4, window 100; 4-bit instance saturates; consumer stalls 10 cycles
    osc_mode = 1;
    repeat (8) @(negedge clk);
    e = '{lo: 24, hi: 26, sat: 0, lo4: 15, hi4: 15, sat4: 1};
    run_meas("fclk4_w100", 100, e, 1'b1);

    // Zero window
    e = '{lo: 0, hi: 0, sat: 0, lo4: 0, hi4: 0, sat4: 0};
    run_meas("w0", 0, e, 1'b0);

    // Single-cycle window, oscillator idle
    osc_mode = 0;
    repeat (8) @(negedge clk);
    e = '{lo: 0, hi: 0, sat: 0, lo4: 0, hi4: 0, sat4: 0};
    run_meas("w1_idle", 1, e, 1'b0);

    // Reset in the middle of a 100-cycle window
    osc_mode = 1;
    repeat (8) @(negedge clk);
    start_v = 1'b1;
    window  = 16'd100;
    @(negedge clk);
    start_v = 1'b0;
    repeat (49) @(negedge clk);
    check("abort.busy_before", int'(busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort.start_ready", int'(start_ready), 0);
    check("abort.count_v", int'(count_v), 0);
    check("abort.count", int'(count), 0);
    check("abort.sat4", int'(saturated4), 0);
    check("abort.busy", int'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort.ready_after", int'(start_ready), 1);
    seen = 0;
    for (int i = 0; i < 110; i++) begin
      if (count_v === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort.no_result", seen, 0);
    $display("txn abort window=100 reset_at=50");
    e = '{lo: 24, hi: 26, sat: 0, lo4: 15, hi4: 15, sat4: 1};
    run_meas("after_abort", 100, e, 1'b0);

    // Single-cycle pulses every 8 cycles, window 80
    osc_mode = 2;
    repeat (16) @(negedge clk);
`ifdef CLK_GEN_FREQ_METER_GLITCH_FILTER_EN
    e = '{lo: 0, hi: 0, sat: 0, lo4: 0, hi4: 0, sat4: 0};
`else
    e = '{lo: 9, hi: 11, sat: 0, lo4: 9, hi4: 11, sat4: 0};
`endif
    run_meas("pulses_w80", 80, e, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
